// File: rtl/fixed_power_pkg.sv
// fixed_power_pkg: shared types and constants for the Q10.10 power unit.
// Also used by the nth-root datapath and its bench, so keep it free of
// anything specific to the power sequencer.
package fixed_power_pkg;

  localparam int W_DEF     = 20;
  localparam int FRAC_DEF  = 10;
  localparam int EXP_W_DEF = 3;

  // 1.0 and the saturated maximum (1023.999) for the default Q10.10 format
  localparam logic [W_DEF-1:0] Q_ONE = 20'h00400;
  localparam logic [W_DEF-1:0] Q_SAT = 20'hFFFFF;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_e;

endpackage

// File: rtl/fixed_power_if.sv
// fixed_power_if: request/response bundle of the power unit.
//   in_valid / in_ready      : request handshake (accepted when both high)
//   in_data_1                : base, unsigned Q10.10
//   in_data_2                : exponent 0..2**EXP_W-1
//   out_valid                : one-cycle result pulse
//   out_data / out_sat       : result and saturation flag, zero unless out_valid
// slave  = the power unit, master = whoever issues requests.
interface fixed_power_if #(
  parameter int W     = 20,
  parameter int EXP_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data_1;
  logic [EXP_W-1:0] in_data_2;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic             out_sat;

  modport slave (
    input  in_valid, in_data_1, in_data_2,
    output in_ready, out_valid, out_data, out_sat
  );

  modport master (
    output in_valid, in_data_1, in_data_2,
    input  in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/fixed_power_q10_mul.sv
// q10_mul: combinational unsigned fixed-point multiply.
//   a_i, b_i : W-bit unsigned operands with FRAC fractional bits
//   p_o      : product truncated toward zero back into the same format
//   ovf_o    : product's integer part does not fit in W-FRAC bits
module q10_mul #(
  parameter int W    = 20,
  parameter int FRAC = 10
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] p_o,
  output logic         ovf_o
);

  logic [2*W-1:0] prod;
  logic           unused_frac;

  assign prod  = a_i * b_i;
  // Drop the low FRAC bits (truncation, no rounding)
  assign p_o   = prod[W+FRAC-1:FRAC];
  // Anything above the integer field of the result is overflow
  assign ovf_o = |prod[2*W-1:W+FRAC];

  assign unused_frac = ^prod[FRAC-1:0];

endmodule

// File: rtl/fixed_power.sv
// fixed_power: iterative Q10.10 exponentiation, out = base ** n.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : fixed_power_if slave (request in, one-cycle result pulse out)
// One multiply per CALC cycle; the accumulator starts at base (or 1.0 for
// n=0) so n-1 multiplies are needed and latency is max(n,1). An overflowing
// multiply saturates and jumps straight to the result cycle.
module fixed_power
  import fixed_power_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int EXP_W = EXP_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  fixed_power_if.slave bus
);

  localparam logic [W-1:0] ONE = W'(1) << FRAC;
  localparam logic [W-1:0] SAT = '1;

  state_e           state_q;
  logic [W-1:0]     base_q;
  logic [EXP_W-1:0] exp_q;
  logic [W-1:0]     acc_q;
  logic [EXP_W-1:0] cnt_q;
  logic             sat_q;
  logic             out_valid_q;
  logic [W-1:0]     out_data_q;
  logic             out_sat_q;

  logic [W-1:0]     mul_p;
  logic             mul_ovf;

  q10_mul #(.W(W), .FRAC(FRAC)) u_mul (
    .a_i   (acc_q),
    .b_i   (base_q),
    .p_o   (mul_p),
    .ovf_o (mul_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      exp_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      // Result outputs are a pulse and read as zero outside it
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            base_q  <= bus.in_data_1;
            exp_q   <= bus.in_data_2;
            acc_q   <= (bus.in_data_2 == '0) ? ONE : bus.in_data_1;
            cnt_q   <= EXP_W'(1);
            sat_q   <= 1'b0;
            state_q <= CALC;
          end
        end
        CALC: begin
          if (cnt_q >= exp_q) begin
            out_valid_q <= 1'b1;
            out_data_q  <= acc_q;
            out_sat_q   <= sat_q;
            state_q     <= IDLE;
          end else if (mul_ovf) begin
            // Further multiplies can only grow (base >= 1 here), so stop now
            acc_q <= SAT;
            sat_q <= 1'b1;
            cnt_q <= exp_q;
          end else begin
            acc_q <= mul_p;
            cnt_q <= cnt_q + EXP_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;

endmodule

// File: tb/tb_fixed_power.sv
// Bench for fixed_power: directed and random requests, a scoreboard of
// expected {data, sat, latency} pushed when a request is driven and popped
// when out_valid appears, plus control corner cases.
module tb_fixed_power;
  import fixed_power_pkg::*;

  typedef struct {
    logic [19:0] d;
    logic        s;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  exp_t eq[$];
  int   aq[$];

  always #5 clk = ~clk;

  fixed_power_if #(.W(20), .EXP_W(3)) bus ();

  fixed_power #(.W(20), .FRAC(10), .EXP_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: repeated truncating Q10.10 multiply with early saturation
  function automatic exp_t model(input logic [19:0] b, input int n);
    exp_t        e;
    logic [63:0] a, p;
    a     = (n == 0) ? 64'(Q_ONE) : 64'(b);
    e.s   = 1'b0;
    e.lat = (n == 0) ? 1 : n;
    for (int i = 1; i < n; i++) begin
      p = a * 64'(b);
      if ((p >> 30) != 0) begin
        a     = 64'(Q_SAT);
        e.s   = 1'b1;
        e.lat = i + 1;
        break;
      end
      a = (p >> 10) & 64'hFFFFF;
    end
    e.d = a[19:0];
    return e;
  endfunction

  // One clock: note an accept at the coming edge, then sample #1 after it
  task automatic tick();
    exp_t e;
    int   ac;
    if (bus.in_valid && bus.in_ready && !rst) aq.push_back(cyc + 1);
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      eq.delete();
      aq.delete();
    end else if (bus.out_valid) begin
      chk("expected_result", 32'(eq.size() > 0 && aq.size() > 0), 1);
      if (eq.size() > 0 && aq.size() > 0) begin
        e  = eq.pop_front();
        ac = aq.pop_front();
        chk("data", 32'(bus.out_data), 32'(e.d));
        chk("sat", 32'(bus.out_sat), 32'(e.s));
        chk("latency", 32'(cyc - ac), 32'(e.lat));
        chk("ready_with_valid", 32'(bus.in_ready), 1);
      end
    end else begin
      chk("idle_outputs_zero", {11'd0, bus.out_sat, bus.out_data}, 0);
    end
  endtask

  task automatic wait_idle();
    int g = 0;
    while (eq.size() != 0 && g < 60) begin
      tick();
      g++;
    end
    chk("result_timeout", 32'(eq.size()), 0);
  endtask

  task automatic req(input logic [19:0] b, input logic [2:0] n, input exp_t e);
    int g = 0;
    while (!bus.in_ready && g < 60) begin
      tick();
      g++;
    end
    chk("ready_timeout", 32'(bus.in_ready), 1);
    bus.in_valid  = 1'b1;
    bus.in_data_1 = b;
    bus.in_data_2 = n;
    eq.push_back(e);
    tick();
    bus.in_valid = 1'b0;
    wait_idle();
  endtask

  function automatic exp_t mk(input logic [19:0] d, input logic s, input int lat);
    exp_t e;
    e.d = d; e.s = s; e.lat = lat;
    return e;
  endfunction

  initial begin
    logic [19:0] rb;
    logic [2:0]  rn;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data_1 = '0;
    bus.in_data_2 = '0;
    repeat (3) tick();
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_out_sat", 32'(bus.out_sat), 0);
    rst = 1'b0;
    tick();

    // Directed values
    req(20'h00800, 3'd3, mk(20'h02000, 1'b0, 3));
    req(20'h00600, 3'd7, mk(20'h04458, 1'b0, 7));
    req(20'h12345, 3'd0, mk(20'h00400, 1'b0, 1));
    req(20'h00ABC, 3'd1, mk(20'h00ABC, 1'b0, 1));
    req(20'h08000, 3'd3, mk(20'hFFFFF, 1'b1, 2));
    req(20'h07C00, 3'd2, mk(20'hF0400, 1'b0, 2));
    req(20'h00001, 3'd2, mk(20'h00000, 1'b0, 2));
    req(20'hFFFFF, 3'd1, mk(20'hFFFFF, 1'b0, 1));
    req(20'h00C00, 3'd7, mk(20'hFFFFF, 1'b1, 7));

    // Random bases around the interesting 0..8.0 range
    for (int k = 0; k < 10; k++) begin
      rb = 20'($urandom_range(0, 20'h02000));
      rn = 3'($urandom_range(0, 7));
      req(rb, rn, model(rb, int'(rn)));
    end

    // in_valid during CALC must not start a second operation
    bus.in_valid  = 1'b1;
    bus.in_data_1 = 20'h00600;
    bus.in_data_2 = 3'd7;
    eq.push_back(mk(20'h04458, 1'b0, 7));
    tick();
    bus.in_data_1 = 20'h00800;
    bus.in_data_2 = 3'd1;
    repeat (3) tick();
    bus.in_valid = 1'b0;
    wait_idle();
    repeat (4) tick();

    // Back-to-back: in_valid held high, accepted in the out_valid cycle
    bus.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rb = 20'h00400 + 20'(k * 20'h00111);
      bus.in_data_1 = rb;
      bus.in_data_2 = 3'd1;
      eq.push_back(mk(rb, 1'b0, 1));
      tick();
      chk("b2b_busy", 32'(bus.in_ready), 0);
      tick();
    end
    bus.in_valid = 1'b0;
    wait_idle();

    // Reset in the middle of a long operation
    bus.in_valid  = 1'b1;
    bus.in_data_1 = 20'h00600;
    bus.in_data_2 = 3'd7;
    eq.push_back(mk(20'h04458, 1'b0, 7));
    tick();
    bus.in_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    chk("midrst_in_ready", 32'(bus.in_ready), 1);
    chk("midrst_out_valid", 32'(bus.out_valid), 0);
    chk("midrst_out_data", 32'(bus.out_data), 0);
    chk("midrst_out_sat", 32'(bus.out_sat), 0);
    rst = 1'b0;
    repeat (10) tick();

    // Still functional after the abort
    req(20'h00800, 3'd2, mk(20'h01000, 1'b0, 2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fixed_power.md
# fixed_power

Iterative Q10.10 fixed-point exponentiation unit: computes `out_data = in_data_1 ** in_data_2` for an unsigned Q10.10 base and a 3-bit exponent. It uses one 20x20 multiply per cycle, truncates every partial product and saturates on overflow. It is the forward (power) direction of the team's nth-root datapath. It is used as the golden checker and stimulus generator for root results (`root(x,n)**n <= x`), and as a standalone power function.

## Interface
Parameters:
- `W`, default 20: data width in Q10.10.
- `FRAC`, default 10: fractional bits.
- `EXP_W`, default 3: exponent width.

Ports:
- `clk`, input, 1: clock; all logic on the rising edge.
- `rst`, input, 1: reset. Synchronous and active-high.
- `in_valid`, input, 1: request strobe. Sampled only while `in_ready` is high.
- `in_data_1`, input, W: base, unsigned Q10.10.
- `in_data_2`, input, EXP_W: exponent n, range 0..7.
- `in_ready`, output, 1: high in the IDLE state.
- `out_valid`, output, 1: one-cycle result pulse.
- `out_data`, output, W: result in Q10.10. Zero whenever `out_valid` is low.
- `out_sat`, output, 1: result saturated. Qualified by `out_valid`; zero otherwise.

## Operation
- States are IDLE and CALC. Internal registers:
  - `base_r` (W), `exp_r` (EXP_W), `acc` (W), `cnt` (EXP_W), `sat_r`.
- IDLE, when `in_valid`=1:
  - Latch `base_r`=`in_data_1` and `exp_r`=`in_data_2`, then go to CALC.
  - `acc` = 20'h00400 (1.0) if n=0, else `in_data_1`.
  - `cnt`=1 and `sat_r`=0.
- IDLE, when `in_valid`=0: hold state. Input data is ignored.
- CALC, when `cnt >= exp_r`:
  - Register `out_valid`=1, `out_data`=`acc`, `out_sat`=`sat_r`.
  - Go to IDLE.
- CALC, otherwise:
  - Compute `prod` = `acc * base_r` as a full 40-bit unsigned product.
  - If `prod[39:30]` != 0: `acc`=20'hFFFFF, `sat_r`=1, `cnt`=`exp_r` (early exit).
  - Else: `acc`=`prod[29:10]` (truncate toward zero, no rounding), `cnt`=`cnt`+1.
- While in CALC, `in_valid` is ignored. There is no queueing.
- Width rules:
  - The multiplier is unsigned 20x20->40.
  - The overflow test covers only the integer bits above Q10.10.
  - 20'hFFFFF (1023.999) is the saturated value. It is also reachable exactly without `sat`.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `out_data`=0, `out_sat`=0. All internal registers are 0.
- Reset asserted mid-CALC aborts the operation. The next cycle is IDLE with no `out_valid` pulse.
- Let the accept edge be E0. `out_valid` rises after edge E(max(n,1)), so latency is max(n,1) cycles.
- Saturation can shorten latency, but never below 1 cycle after the overflowing multiply.
- `out_valid` is high for exactly one cycle. `in_ready` is high in that same cycle, so back-to-back requests are accepted with no gap.
- In IDLE, `in_valid` held high starts a new operation on every accept opportunity.

## Structure
- Package `fixed_power_pkg`:
  - State enum {IDLE, CALC}.
  - `Q_ONE`=20'h00400 and `Q_SAT`=20'hFFFFF.
  - W, FRAC and EXP_W defaults.
  - Shared with the root block and its bench.
- Sub-module `q10_mul`:
  - Combinational.
  - Takes two W-bit operands.
  - Returns the truncated W-bit product plus an `ovf` flag.
  - Reused by the root datapath.

## Test plan
- Base 0x00800 (2.0), n=3:
  - `out_data`=0x02000, `out_sat`=0.
  - `out_valid` 3 cycles after accept.
- Base 0x00600 (1.5), n=7: `out_data`=0x04458 (17.0859375), 7 cycles.
- Exponent corners:
  - n=0 with any base, e.g. 0x12345: `out_data`=0x00400, latency 1.
  - n=1 with base 0x00ABC: `out_data`=0x00ABC, latency 1.
- Saturation:
  - Base 0x08000 (32.0), n=3: `out_data`=0xFFFFF, `out_sat`=1, `out_valid` 2 cycles after accept.
  - Base 0x07C00 (31.0), n=2: `out_data`=0xF0400, `out_sat`=0.
- Truncation: base 0x00001, n=2 -> `out_data`=0, `out_sat`=0.
- Control:
  - `in_valid` pulsed mid-CALC is ignored; only the first result appears.
  - Back-to-back requests are accepted in the same cycle as the `out_valid` pulse.
  - `rst` asserted mid-CALC: no `out_valid`, all outputs return to their reset values on the next cycle.
